// File: rtl/alu_pkg.sv
// Shared definitions for the serial-opcode ALU driver and its reference model:
// default operand width, opcode encodings and the driver FSM states.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;
    localparam int unsigned ALU_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        SEND2,
        WAIT,
        RESP
    } drv_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU: expected result and carry/borrow for
// an operation, usable by the driver and by standalone ALU checkers.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] exp_result,
    output logic                  exp_overflow
);

    logic [DATA_WIDTH:0] wide;

    // Arithmetic is done one bit wider so the top bit carries out (add) or borrows (sub).
    always_comb begin
        wide         = '0;
        exp_overflow = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                wide         = {1'b0, a} + {1'b0, b};
                exp_overflow = wide[DATA_WIDTH];
            end
            OP_SUB: begin
                wide         = {1'b0, a} - {1'b0, b};
                exp_overflow = wide[DATA_WIDTH];
            end
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_XNOR: wide = {1'b0, ~(a ^ b)};
            default: wide = '0;
        endcase
        exp_result = wide[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/alu_driver.sv
// Drives one request into a serial-opcode ALU (two operand strobes), waits a
// bounded time for alu_done, and returns the captured result with status.
module alu_driver
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  rsp_mismatch
);

    localparam logic [ALU_CNT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT[ALU_CNT_WIDTH-1:0];

    drv_state_e              state, state_next;
    logic [ALU_CNT_WIDTH-1:0] wait_cnt;
    alu_op_e                 op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [DATA_WIDTH-1:0]   exp_result;
    logic                    exp_overflow;
    logic                    accept, capture, expire;

    alu_ref_model #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ref (
        .op           (op_q),
        .a            (a_q),
        .b            (b_q),
        .exp_result   (exp_result),
        .exp_overflow (exp_overflow)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= alu_op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state == SEND2) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                rsp_result   <= alu_result;
                rsp_overflow <= alu_overflow;
                rsp_timeout  <= 1'b0;
                rsp_mismatch <= (alu_result != exp_result) || (alu_overflow != exp_overflow);
            end else if (expire) begin
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_timeout  <= 1'b1;
                rsp_mismatch <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        capture      = 1'b0;
        expire       = 1'b0;
        req_ready    = 1'b0;
        opcode_valid = 1'b0;
        opcode       = 1'b0;
        data         = '0;
        rsp_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = SEND1;
                end
            end
            SEND1: begin
                opcode_valid = 1'b1;
                opcode       = op_q[0];
                data         = a_q;
                state_next   = SEND2;
            end
            SEND2: begin
                opcode_valid = 1'b1;
                opcode       = op_q[1];
                data         = b_q;
                state_next   = WAIT;
            end
            WAIT: begin
                // wait_cnt counts completed WAIT cycles, so this is cycle wait_cnt+1.
                if (alu_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt + 1'b1 >= TIMEOUT_CNT) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Handshake and bus outputs are held quiet for as long as reset is asserted.
        if (!reset_n) begin
            req_ready    = 1'b0;
            opcode_valid = 1'b0;
            opcode       = 1'b0;
            data         = '0;
            rsp_valid    = 1'b0;
        end
    end

endmodule
